// File: rtl/axis_pkg.sv
// ============================================================================
// Module      : axis_pkg
// Description : Shared FSM state type and per-lane keep-mask helper for
//               packet_to_axis.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Keep mask from remainder: a zero remainder means the beat is completely full.
    // Evaluated one lane at a time so callers only build the lanes they have.
    function automatic logic keep_mask_bit(input int unsigned rem,
                                           input int unsigned lane,
                                           input int unsigned lanes);
        if (rem == 0)
            return (lane < lanes);
        return (lane < rem);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_keep_gen.sv
// ============================================================================
// Module      : axis_keep_gen
// Description : Converts a byte remainder into the last-beat tkeep mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_keep_gen
    import axis_pkg::*;
#(
    parameter int KEEP_WIDTH = 8,
    parameter int REM_WIDTH  = 3
) (
    input  logic [REM_WIDTH-1:0]  rem,
    output logic [KEEP_WIDTH-1:0] keep
);

    for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
        assign keep[i] = keep_mask_bit(32'(rem), 32'(i), 32'(KEEP_WIDTH));
    end

endmodule

`default_nettype wire

// File: rtl/packet_to_axis.sv
// ============================================================================
// Module      : packet_to_axis
// Description : Registers a whole packet and streams it out as AXI-Stream
//               beats. Define PACKET_TO_AXIS_LEN_CHECK_EN to drop bad lengths
//               with an err pulse instead of clamping them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_to_axis
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int PKT_BYTES  = 64,
    parameter int LEN_WIDTH  = $clog2(PKT_BYTES + 1),
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PKT_BYTES*8-1:0] pkt_data,
    input  logic [LEN_WIDTH-1:0]   pkt_len,
    input  logic [ID_WIDTH-1:0]    pkt_id,
    input  logic [DEST_WIDTH-1:0]  pkt_dest,
    input  logic [USER_WIDTH-1:0]  pkt_user,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic [ID_WIDTH-1:0]    m_axis_tid,
    output logic [DEST_WIDTH-1:0]  m_axis_tdest,
    output logic [USER_WIDTH-1:0]  m_axis_tuser,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic                   err
);

    localparam int                   C_REM_WIDTH = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;
    localparam logic [LEN_WIDTH-1:0] C_MAX_LEN   = LEN_WIDTH'(PKT_BYTES);
    localparam logic [LEN_WIDTH-1:0] C_LANES     = LEN_WIDTH'(KEEP_WIDTH);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [PKT_BYTES*8-1:0]  r_data;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_beat;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DEST_WIDTH-1:0]   r_dest;
    logic [USER_WIDTH-1:0]   r_user;

    logic                    w_accept;
    logic                    w_drop;
    logic                    w_beat_fire;
    logic                    w_is_last;
    logic [LEN_WIDTH-1:0]    w_len_clamped;
    logic [LEN_WIDTH-1:0]    w_last_idx;
    logic [C_REM_WIDTH-1:0]  w_rem;
    logic [KEEP_WIDTH-1:0]   w_keep_last;
    logic [KEEP_WIDTH-1:0]   w_keep;
    logic [DATA_WIDTH-1:0]   w_beat_data;

    assign w_accept      = pkt_valid && (r_state == IDLE);
    assign w_len_clamped = (pkt_len > C_MAX_LEN) ? C_MAX_LEN : pkt_len;
    assign w_beat_fire   = m_axis_tvalid && m_axis_tready;

`ifdef PACKET_TO_AXIS_LEN_CHECK_EN
    logic r_err;

    assign w_drop = (pkt_len == '0) || (pkt_len > C_MAX_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else
            r_err <= w_accept && w_drop;
    end

    assign err = r_err;
`else
    assign w_drop = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_drop) w_next_state = SEND;
            SEND:    if (w_beat_fire && w_is_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_len  <= '0;
            r_beat <= '0;
            r_id   <= '0;
            r_dest <= '0;
            r_user <= '0;
        end else if (w_accept && !w_drop) begin
            r_data <= pkt_data;
            r_len  <= w_len_clamped;
            r_beat <= '0;
            r_id   <= pkt_id;
            r_dest <= pkt_dest;
            r_user <= pkt_user;
        end else if (w_beat_fire && !w_is_last) begin
            r_beat <= r_beat + LEN_WIDTH'(1);
        end
    end

    // A zero-length packet still occupies one (empty) beat.
    assign w_last_idx = (r_len == '0) ? '0 : (r_len - LEN_WIDTH'(1)) / C_LANES;
    assign w_is_last  = (r_beat == w_last_idx);
    assign w_rem      = C_REM_WIDTH'(r_len % C_LANES);

    axis_keep_gen #(
        .KEEP_WIDTH (KEEP_WIDTH),
        .REM_WIDTH  (C_REM_WIDTH)
    ) u_keep_gen (
        .rem  (w_rem),
        .keep (w_keep_last)
    );

    always_comb begin
        w_keep = '0;
        if (r_state == SEND) begin
            if (!w_is_last)
                w_keep = '1;
            else if (r_len != '0)
                w_keep = w_keep_last;
        end
    end

    assign w_beat_data = r_data[r_beat * DATA_WIDTH +: DATA_WIDTH];

    // Unkept lanes are forced to zero, which also blanks tdata outside SEND.
    for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane_data
        assign m_axis_tdata[8*i +: 8] = w_keep[i] ? w_beat_data[8*i +: 8] : 8'h00;
    end

    assign m_axis_tkeep  = w_keep;
    assign m_axis_tvalid = (r_state == SEND);
    assign m_axis_tlast  = (r_state == SEND) && w_is_last;
    assign m_axis_tid    = (r_state == SEND) ? r_id   : '0;
    assign m_axis_tdest  = (r_state == SEND) ? r_dest : '0;
    assign m_axis_tuser  = (r_state == SEND) ? r_user : '0;
    assign pkt_ready     = (r_state == IDLE);
    assign busy          = (r_state == SEND);

endmodule

`default_nettype wire

// File: tb/tb_packet_to_axis.sv
// ============================================================================
// Module      : tb_packet_to_axis
// Description : Self-checking bench for packet_to_axis (table, directed and
//               random packets against a byte-level reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_packet_to_axis;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int PB = 64;
    localparam int LW = 7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PB*8-1:0] pkt_data = '0;
    logic [LW-1:0]   pkt_len = '0;
    logic [7:0]      pkt_id = '0;
    logic [7:0]      pkt_dest = '0;
    logic [0:0]      pkt_user = '0;
    logic            pkt_valid = 1'b0;
    logic            pkt_ready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic [7:0]      m_axis_tid;
    logic [7:0]      m_axis_tdest;
    logic [0:0]      m_axis_tuser;
    logic            m_axis_tready = 1'b1;
    logic            busy;
    logic            err;

    packet_to_axis dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pkt_data      (pkt_data),
        .pkt_len       (pkt_len),
        .pkt_id        (pkt_id),
        .pkt_dest      (pkt_dest),
        .pkt_user      (pkt_user),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [7:0]    id;
        logic [7:0]    dest;
        logic [0:0]    user;
        int            cyc;
    } beat_t;

    typedef struct {
        int          len;
        int          nbeats;
        logic [7:0]  last_keep;
        logic [63:0] d0;
        logic        drop;
    } vec_t;

    beat_t      cap[$];
    beat_t      exp_q[$];
    logic [7:0] pbytes[PB];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         err_pulses = 0;
    int         tr_mode = 0;
    logic       exp_drop = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input beat_t b);
        return {38'b0, b.data, b.keep, b.last, b.id, b.dest, b.user};
    endfunction

    function automatic beat_t cur_beat();
        beat_t b;
        b.data = m_axis_tdata;
        b.keep = m_axis_tkeep;
        b.last = m_axis_tlast;
        b.id   = m_axis_tid;
        b.dest = m_axis_tdest;
        b.user = m_axis_tuser;
        b.cyc  = cyc;
        return b;
    endfunction

    // Monitor: sampled mid-cycle, records handshaken beats and checks stall stability.
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    always @(negedge clk) begin
        beat_t b;
        cyc++;
        b = cur_beat();
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("busy_ready", 128'({busy, pkt_ready}), 128'({m_axis_tvalid, !m_axis_tvalid}));
            if (prev_stall)
                chk("stall_stable", pk(b), pk(prev_beat));
            if (err)
                err_pulses++;
            if (m_axis_tvalid && m_axis_tready)
                cap.push_back(b);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = b;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model: place each valid byte at beat b/KW, lane b%KW.
    task automatic build_expected(input int len, input logic [7:0] id, input logic [7:0] dest,
                                  input logic [0:0] user);
        int    eff;
        int    nb;
        beat_t b;
        exp_q.delete();
        exp_drop = 1'b0;
`ifdef PACKET_TO_AXIS_LEN_CHECK_EN
        if (len == 0 || len > PB) begin
            exp_drop = 1'b1;
            return;
        end
`endif
        eff = (len > PB) ? PB : len;
        nb  = (eff == 0) ? 1 : (eff + KW - 1) / KW;
        for (int k = 0; k < nb; k++) begin
            b.data = '0;
            b.keep = '0;
            b.last = (k == nb - 1);
            b.id   = id;
            b.dest = dest;
            b.user = user;
            b.cyc  = 0;
            for (int j = 0; j < KW; j++) begin
                if (k * KW + j < eff) begin
                    b.keep[j]       = 1'b1;
                    b.data[8*j +: 8] = pbytes[k * KW + j];
                end
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic send_pkt(input int len, input logic [7:0] id, input logic [7:0] dest,
                            input logic [0:0] user);
        int guard = 0;
        while (!pkt_ready && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500)
            chk("ready_timeout", 128'(guard), 128'(0));
        for (int i = 0; i < PB; i++)
            pkt_data[8*i +: 8] = pbytes[i];
        pkt_len   = LW'(len);
        pkt_id    = id;
        pkt_dest  = dest;
        pkt_user  = user;
        pkt_valid = 1'b1;
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 1000)
            chk("idle_timeout", 128'(g), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name, input int err_base);
        int n;
        chk({name, "_nbeats"}, 128'(cap.size()), 128'(exp_q.size()));
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({name, "_beat"}, pk(cap[i]), pk(exp_q[i]));
        chk({name, "_err"}, 128'(err_pulses - err_base), 128'(exp_drop));
    endtask

    vec_t vt[8];

    initial begin
        int    eb;
        int    len;
        beat_t tmp[$];

        vt[0] = '{20, 3, 8'h0F, 64'h0706050403020100, 1'b0};
        vt[1] = '{64, 8, 8'hFF, 64'h0706050403020100, 1'b0};
        vt[2] = '{8,  1, 8'hFF, 64'h0706050403020100, 1'b0};
        vt[3] = '{9,  2, 8'h01, 64'h0706050403020100, 1'b0};
        vt[4] = '{1,  1, 8'h01, 64'h0000000000000000, 1'b0};
        vt[5] = '{63, 8, 8'h7F, 64'h0706050403020100, 1'b0};
`ifdef PACKET_TO_AXIS_LEN_CHECK_EN
        vt[6] = '{0,  0, 8'h00, 64'h0, 1'b1};
        vt[7] = '{65, 0, 8'h00, 64'h0, 1'b1};
`else
        vt[6] = '{0,  1, 8'h00, 64'h0000000000000000, 1'b0};
        vt[7] = '{65, 8, 8'hFF, 64'h0706050403020100, 1'b0};
`endif

        // Reset values while rst_n is held low.
        #2;
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_tlast",  128'(m_axis_tlast),  128'(0));
        chk("rst_tkeep",  128'(m_axis_tkeep),  128'(0));
        chk("rst_tdata",  128'(m_axis_tdata),  128'(0));
        chk("rst_side",   128'({m_axis_tid, m_axis_tdest, m_axis_tuser}), 128'(0));
        chk("rst_busy_err", 128'({busy, err}), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 128'(pkt_ready), 128'(1));

        // Table vectors, ramp bytes 0x00.., tready held high.
        tr_mode = 0;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < PB; i++)
                pbytes[i] = 8'(i);
            cap.delete();
            eb = err_pulses;
            send_pkt(vt[v].len, 8'(v + 1), 8'(8'hA0 + v), 1'(v));
            wait_idle();
            build_expected(vt[v].len, 8'(v + 1), 8'(8'hA0 + v), 1'(v));
            compare("vec", eb);
            chk("vec_count", 128'(cap.size()), 128'(vt[v].nbeats));
            chk("vec_drop",  128'(err_pulses - eb), 128'(vt[v].drop));
            if (cap.size() > 0) begin
                chk("vec_last_keep", 128'(cap[cap.size()-1].keep), 128'(vt[v].last_keep));
                chk("vec_last_flag", 128'(cap[cap.size()-1].last), 128'(1));
                chk("vec_d0",        128'(cap[0].data), 128'(vt[v].d0));
            end
        end

        // Full packet with tready toggling every cycle.
        tr_mode = 1;
        for (int i = 0; i < PB; i++)
            pbytes[i] = 8'($urandom);
        cap.delete();
        eb = err_pulses;
        send_pkt(64, 8'h11, 8'h22, 1'b1);
        wait_idle();
        build_expected(64, 8'h11, 8'h22, 1'b1);
        compare("toggle", eb);

        // Back-to-back packets: one IDLE bubble between them.
        tr_mode = 0;
        for (int i = 0; i < PB; i++)
            pbytes[i] = 8'(8'h40 + i);
        cap.delete();
        eb = err_pulses;
        send_pkt(8, 8'd3, 8'h01, 1'b0);
        send_pkt(9, 8'd4, 8'h02, 1'b1);
        wait_idle();
        build_expected(8, 8'd3, 8'h01, 1'b0);
        tmp = exp_q;
        build_expected(9, 8'd4, 8'h02, 1'b1);
        exp_q = {tmp, exp_q};
        compare("b2b", eb);
        if (cap.size() >= 3) begin
            chk("b2b_gap", 128'(cap[1].cyc - cap[0].cyc), 128'(2));
            chk("b2b_ids", 128'({cap[0].id, cap[1].id, cap[2].id}), 128'({8'd3, 8'd4, 8'd4}));
        end

        // Reset during the second beat of a 32-byte packet.
        cap.delete();
        send_pkt(32, 8'h77, 8'h88, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", 128'({m_axis_tvalid, m_axis_tkeep, busy}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", 128'(pkt_ready), 128'(1));
        repeat (10) @(posedge clk);
        #1;
        build_expected(32, 8'h77, 8'h88, 1'b0);
        chk("midrst_leftover", 128'(cap.size()), 128'(1));
        if (cap.size() > 0)
            chk("midrst_beat0", pk(cap[0]), pk(exp_q[0]));

        // Random packets with random backpressure, including out-of-range lengths.
        tr_mode = 2;
        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < PB; i++)
                pbytes[i] = 8'($urandom);
            len = (p % 6 == 0) ? int'($urandom_range(0, 70)) : int'($urandom_range(1, PB));
            cap.delete();
            eb = err_pulses;
            send_pkt(len, 8'($urandom), 8'($urandom), 1'($urandom));
            wait_idle();
            build_expected(len, pkt_id, pkt_dest, pkt_user);
            compare("rand", eb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/packet_to_axis.md
PACKET_TO_AXIS -- requirements
Module: packet_to_axis

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, AXI stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte lanes per beat.
REQ-003 SHALL have parameter PKT_BYTES, default 64, maximum packet size in bytes (multiple of KEEP_WIDTH).
REQ-004 SHALL have parameter LEN_WIDTH, default $clog2(PKT_BYTES+1), packet length field width.
REQ-005 SHALL have parameters ID_WIDTH 8, DEST_WIDTH 8, USER_WIDTH 1, sideband widths.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have ports pkt_data input PKT_BYTES*8 (packet, byte 0 in [7:0]); pkt_len input LEN_WIDTH (valid bytes); pkt_id/pkt_dest/pkt_user inputs ID/DEST/USER_WIDTH.
REQ-009 SHALL have ports pkt_valid input 1 and pkt_ready output 1, packet handshake.
REQ-010 SHALL have ports m_axis_tdata DATA_WIDTH, m_axis_tkeep KEEP_WIDTH, m_axis_tvalid 1, m_axis_tlast 1, m_axis_tid ID_WIDTH, m_axis_tdest DEST_WIDTH, m_axis_tuser USER_WIDTH outputs; m_axis_tready input 1.
REQ-011 SHALL have outputs busy 1 (packet in flight) and err 1 (one-cycle length-error pulse).

Function
REQ-012 SHALL implement FSM IDLE, SEND; pkt_ready = 1 only in IDLE.
REQ-013 On pkt_valid && pkt_ready: register whole packet, len, id, dest, user; beat index = 0; go to SEND next cycle.
REQ-014 SHALL assert m_axis_tvalid the cycle after acceptance (1-cycle latency) and hold it until last beat handshake.
REQ-015 Beat k SHALL carry packet bytes k*KEEP_WIDTH .. k*KEEP_WIDTH+KEEP_WIDTH-1, byte 0 of each beat in lane 0.
REQ-016 Beat count SHALL be ceil(len/KEEP_WIDTH); tkeep all-ones except last beat: lowest (len mod KEEP_WIDTH) bits set, all-ones when remainder 0.
REQ-017 m_axis_tlast SHALL be 1 on last beat only; tid/tdest/tuser constant across all beats of a packet.
REQ-018 While tvalid && !tready all m_axis_* outputs SHALL be held stable; beat index advances only on tvalid && tready.
REQ-019 After last-beat handshake SHALL return to IDLE; next packet accepted no earlier than that IDLE cycle (one bubble between packets).
REQ-020 busy SHALL be 1 in SEND, 0 in IDLE; err 0 except per REQ-026.
REQ-021 Bytes of tdata in lanes with tkeep=0 SHALL be zero.

Reset
REQ-022 On rst_n low, asynchronously: state IDLE, pkt_ready 1 after release, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tkeep 0, tdata/tid/tdest/tuser 0, busy 0, err 0.
REQ-023 Reset mid-packet SHALL abandon the packet; no further beats emitted after release.

Configuration
REQ-024 Macro PACKET_TO_AXIS_LEN_CHECK_EN SHALL select length-error handling.
REQ-025 Without it: len 0 SHALL emit one beat, tkeep 0, tlast 1; len > PKT_BYTES SHALL be clamped to PKT_BYTES; err tied 0.
REQ-026 With it: len 0 or len > PKT_BYTES SHALL be accepted, dropped with no output beat, err pulsed 1 for the cycle after acceptance, FSM stays IDLE.

Structure
REQ-027 Shared package axis_pkg SHALL hold the state enum (IDLE, SEND) and a keep-mask-from-remainder function.
REQ-028 Sub-module axis_keep_gen (remainder -> tkeep mask) is natural; beat mux and FSM stay in packet_to_axis.

Verification (DATA_WIDTH 64, PKT_BYTES 64)
REQ-029 len 20, bytes 0x00..0x13, tready=1 -> 3 beats, tkeep FF,FF,0F, tlast on beat 3, beat 1 tdata 0x0706050403020100.
REQ-030 len 64, tready toggling 1/0 each cycle -> 8 beats, all tkeep FF, outputs stable during stalls, busy 1 throughout.
REQ-031 Two back-to-back packets (len 8, id 3; len 9, id 4) -> 1, then 2 beats; tid 3 then 4; one IDLE cycle between.
REQ-032 rst_n low during beat 2 of len-32 packet -> tvalid 0 immediately, pkt_ready 1 after release, no leftover beats.
REQ-033 len 0 and len 65: macro off -> one tkeep-0 tlast beat / 8 beats; macro on -> no beats, err one-cycle pulse each.
